// File: rtl/iic_cfg_sequencer.sv
// iic_cfg_sequencer: walks a register-init table and feeds iic_drive one
// transfer at a time, with per-entry retry, optional read-back verify,
// delay entries and an end marker.
module iic_cfg_sequencer #(
  parameter logic [7:0] DEV_ADDR     = 8'h78,
  parameter int         TBL_AW       = 6,
  parameter int         MAX_RETRY    = 3,
  parameter int         DELAY_UNIT   = 800,
  parameter int         VERIFY       = 0,
  parameter int         BUSY_TIMEOUT = 16
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              cfg_start,
  output logic              cfg_busy,
  output logic              cfg_done,
  output logic              cfg_fail,
  output logic [TBL_AW-1:0] fail_index,
  output logic [TBL_AW-1:0] tbl_addr,
  input  logic [23:0]       tbl_data,
  output logic              drv_start_en,
  output logic              drv_wr_rd_flag,
  output logic [7:0]        drv_dev_addr,
  output logic [15:0]       drv_register,
  output logic [7:0]        drv_data_byte,
  input  logic              drv_busy,
  input  logic              drv_err,
  input  logic [7:0]        drv_rd_data
);

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int DW = $clog2(255 * DELAY_UNIT + 1);
  localparam int TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

  localparam logic [RW-1:0]     RETRY_LIM = RW'(MAX_RETRY);
  localparam logic [TW-1:0]     TO_LAST   = TW'(BUSY_TIMEOUT - 1);
  localparam logic [DW-1:0]     UNIT      = DW'(DELAY_UNIT);
  localparam logic [TBL_AW-1:0] IDX_LAST  = '1;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_ROMWAIT, S_DECODE, S_PREP, S_ISSUE,
    S_WAIT_H, S_WAIT_L, S_CHECK, S_DLY, S_DONE, S_FAIL
  } state_t;

  state_t            state, next_state;
  logic [TBL_AW-1:0] idx;
  logic [RW-1:0]     retry;
  logic [DW-1:0]     dly_cnt;
  logic [TW-1:0]     to_cnt;
  logic              timed_out;

  logic entry_end, entry_dly, dly_zero, idx_last;
  logic xfer_fail, can_retry, verify_next, busy_timeout, start_ok;

  assign drv_dev_addr = DEV_ADDR;

  assign entry_end    = (tbl_data[23:8] == 16'hFFFE);
  assign entry_dly    = (tbl_data[23:8] == 16'hFFFF);
  assign dly_zero     = (tbl_data[7:0] == 8'h00);
  assign idx_last     = (idx == IDX_LAST);
  // A verify read compares against the byte that was just written.
  assign xfer_fail    = timed_out | drv_err |
                        (drv_wr_rd_flag && (drv_rd_data != drv_data_byte));
  assign can_retry    = (retry < RETRY_LIM);
  assign verify_next  = (VERIFY != 0) && !drv_wr_rd_flag;
  assign busy_timeout = !drv_busy && (to_cnt == TO_LAST);
  assign start_ok     = cfg_start &&
                        ((state == S_IDLE) || (state == S_DONE) || (state == S_FAIL));

  // State register.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  // Next-state decode and Moore outputs.
  always_comb begin
    next_state   = state;
    cfg_busy     = 1'b1;
    cfg_done     = 1'b0;
    cfg_fail     = 1'b0;
    drv_start_en = 1'b0;
    unique case (state)
      S_IDLE: begin
        cfg_busy = 1'b0;
        if (cfg_start) next_state = S_FETCH;
      end
      S_FETCH:   next_state = S_ROMWAIT;
      S_ROMWAIT: next_state = S_DECODE;
      S_DECODE: begin
        if (entry_end)      next_state = S_DONE;
        else if (entry_dly) next_state = dly_zero ? (idx_last ? S_DONE : S_FETCH) : S_DLY;
        else                next_state = S_PREP;
      end
      S_PREP: if (!drv_busy) next_state = S_ISSUE;
      S_ISSUE: begin
        drv_start_en = 1'b1;
        next_state   = S_WAIT_H;
      end
      S_WAIT_H: begin
        if (drv_busy)          next_state = S_WAIT_L;
        else if (busy_timeout) next_state = S_CHECK;
      end
      S_WAIT_L: if (!drv_busy) next_state = S_CHECK;
      S_CHECK: begin
        if (xfer_fail)        next_state = can_retry ? S_PREP : S_FAIL;
        else if (verify_next) next_state = S_PREP;
        else                  next_state = idx_last ? S_DONE : S_FETCH;
      end
      S_DLY: if (dly_cnt == '0) next_state = idx_last ? S_DONE : S_FETCH;
      S_DONE: begin
        cfg_busy = 1'b0;
        cfg_done = 1'b1;
        if (cfg_start) next_state = S_FETCH;
      end
      S_FAIL: begin
        cfg_busy = 1'b0;
        cfg_fail = 1'b1;
        if (cfg_start) next_state = S_FETCH;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Table index, retry count, latched entry and the delay/timeout counters.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      idx            <= '0;
      retry          <= '0;
      tbl_addr       <= '0;
      fail_index     <= '0;
      drv_register   <= '0;
      drv_data_byte  <= '0;
      drv_wr_rd_flag <= 1'b0;
      dly_cnt        <= '0;
      to_cnt         <= '0;
      timed_out      <= 1'b0;
    end else if (start_ok) begin
      idx            <= '0;
      retry          <= '0;
      fail_index     <= '0;
      drv_wr_rd_flag <= 1'b0;
    end else begin
      unique case (state)
        S_FETCH: tbl_addr <= idx;
        S_DECODE: begin
          retry          <= '0;
          drv_wr_rd_flag <= 1'b0;
          if (entry_dly) begin
            if (dly_zero) idx <= idx + TBL_AW'(1);
            else          dly_cnt <= DW'(tbl_data[7:0]) * UNIT - DW'(1);
          end else if (!entry_end) begin
            drv_register  <= tbl_data[23:8];
            drv_data_byte <= tbl_data[7:0];
          end
        end
        S_ISSUE: begin
          to_cnt    <= '0;
          timed_out <= 1'b0;
        end
        S_WAIT_H: begin
          if (!drv_busy)    to_cnt <= to_cnt + TW'(1);
          if (busy_timeout) timed_out <= 1'b1;
        end
        S_CHECK: begin
          if (xfer_fail) begin
            if (can_retry) retry <= retry + RW'(1);
            else           fail_index <= idx;
          end else if (verify_next) begin
            drv_wr_rd_flag <= 1'b1;
          end else begin
            retry <= '0;
            idx   <= idx + TBL_AW'(1);
          end
        end
        S_DLY: begin
          if (dly_cnt == '0) idx <= idx + TBL_AW'(1);
          else               dly_cnt <= dly_cnt - DW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iic_cfg_sequencer.sv
// tb_iic_cfg_sequencer: directed bench for iic_cfg_sequencer. Instance A runs
// with VERIFY = 0, instance B with VERIFY = 1 and a 4-entry table.
module tb_iic_cfg_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // Free-running cycle stamp used to time start_en pulses.
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- instance A (VERIFY = 0, DELAY_UNIT = 10) ----------------
  logic        a_cfg_start, a_cfg_busy, a_done, a_fail;
  logic [5:0]  a_fail_index, a_tbl_addr;
  logic [23:0] a_rom;
  logic        a_start, a_wr_rd;
  logic [7:0]  a_dev, a_data;
  logic [15:0] a_reg;
  logic        a_drv_busy, a_drv_err;
  logic [23:0] a_mem [64];
  int          a_cnt = 0;
  int          a_hits = 0;
  int          a_nack_lim;
  logic [15:0] a_nack_reg;
  bit          a_dead, a_stuck;
  int          a_n = 0;
  logic [15:0] a_log_reg [256];
  logic [7:0]  a_log_dat [256];
  logic        a_log_rd  [256];
  int          a_log_cyc [256];

  iic_cfg_sequencer #(
    .DEV_ADDR(8'h78), .TBL_AW(6), .MAX_RETRY(3), .DELAY_UNIT(10),
    .VERIFY(0), .BUSY_TIMEOUT(16)
  ) u_a (
    .clk_i(clk), .rst_n(rst_n), .cfg_start(a_cfg_start),
    .cfg_busy(a_cfg_busy), .cfg_done(a_done), .cfg_fail(a_fail),
    .fail_index(a_fail_index), .tbl_addr(a_tbl_addr), .tbl_data(a_rom),
    .drv_start_en(a_start), .drv_wr_rd_flag(a_wr_rd), .drv_dev_addr(a_dev),
    .drv_register(a_reg), .drv_data_byte(a_data),
    .drv_busy(a_drv_busy), .drv_err(a_drv_err), .drv_rd_data(8'h00)
  );

  // Synchronous table ROM with one cycle of latency.
  always @(posedge clk) a_rom <= a_mem[a_tbl_addr];

  // Driver model: busy from reset, NACKs a chosen register a set number of
  // times, can ignore starts (dead) or hold busy forever (stuck).
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_drv_busy <= 1'b1;
      a_cnt      <= 4;
      a_drv_err  <= 1'b0;
    end else if (a_start && !a_dead) begin
      a_drv_busy <= 1'b1;
      a_cnt      <= 6;
      a_drv_err  <= (a_reg == a_nack_reg) && (a_hits < a_nack_lim);
      if (a_reg == a_nack_reg) a_hits <= a_hits + 1;
    end else if (a_cnt > 0) begin
      a_cnt <= a_cnt - 1;
      if (a_cnt == 1 && !a_stuck) a_drv_busy <= 1'b0;
    end
  end

  // ---------------- instance B (VERIFY = 1, 4-entry table) ----------------
  logic        b_cfg_start, b_cfg_busy, b_done, b_fail;
  logic [1:0]  b_fail_index, b_tbl_addr;
  logic [23:0] b_rom;
  logic        b_start, b_wr_rd;
  logic [7:0]  b_dev, b_data, b_rd_val;
  logic [15:0] b_reg;
  logic        b_drv_busy;
  logic [23:0] b_mem [4];
  int          b_cnt = 0;
  int          b_n = 0;
  logic [15:0] b_log_reg [256];
  logic        b_log_rd  [256];

  iic_cfg_sequencer #(
    .DEV_ADDR(8'h78), .TBL_AW(2), .MAX_RETRY(3), .DELAY_UNIT(10),
    .VERIFY(1), .BUSY_TIMEOUT(16)
  ) u_b (
    .clk_i(clk), .rst_n(rst_n), .cfg_start(b_cfg_start),
    .cfg_busy(b_cfg_busy), .cfg_done(b_done), .cfg_fail(b_fail),
    .fail_index(b_fail_index), .tbl_addr(b_tbl_addr), .tbl_data(b_rom),
    .drv_start_en(b_start), .drv_wr_rd_flag(b_wr_rd), .drv_dev_addr(b_dev),
    .drv_register(b_reg), .drv_data_byte(b_data),
    .drv_busy(b_drv_busy), .drv_err(1'b0), .drv_rd_data(b_rd_val)
  );

  // Synchronous table ROM for B.
  always @(posedge clk) b_rom <= b_mem[b_tbl_addr];

  // Driver model for B: always ACKs, read data is whatever b_rd_val holds.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_drv_busy <= 1'b1;
      b_cnt      <= 4;
    end else if (b_start) begin
      b_drv_busy <= 1'b1;
      b_cnt      <= 5;
    end else if (b_cnt > 0) begin
      b_cnt <= b_cnt - 1;
      if (b_cnt == 1) b_drv_busy <= 1'b0;
    end
  end

  // Log every start_en pulse and latch any invariant violation.
  bit viol = 1'b0;
  always @(posedge clk) begin
    if (a_start) begin
      a_log_reg[a_n] <= a_reg;
      a_log_dat[a_n] <= a_data;
      a_log_rd[a_n]  <= a_wr_rd;
      a_log_cyc[a_n] <= cyc;
      a_n            <= a_n + 1;
    end
    if (b_start) begin
      b_log_reg[b_n] <= b_reg;
      b_log_rd[b_n]  <= b_wr_rd;
      b_n            <= b_n + 1;
    end
    if ((a_start && a_drv_busy) || (b_start && b_drv_busy)) viol <= 1'b1;
    if ((a_done && a_fail) || (b_done && b_fail))           viol <= 1'b1;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input bit sel);
    @(negedge clk);
    if (sel) b_cfg_start = 1'b1;
    else     a_cfg_start = 1'b1;
    @(negedge clk);
    a_cfg_start = 1'b0;
    b_cfg_start = 1'b0;
  endtask

  task automatic wait_end(input bit sel, input string tag);
    int n = 0;
    while (!(sel ? (b_done || b_fail) : (a_done || a_fail)) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check_output({tag, "_finished"}, 32'(n < 4000), 32'd1);
  endtask

  int base, ga, gb, n;

  initial begin
    rst_n = 1'b0;
    a_cfg_start = 1'b0; b_cfg_start = 1'b0;
    a_dead = 1'b0; a_stuck = 1'b0;
    a_nack_reg = 16'h3103; a_nack_lim = 0;
    b_rd_val = 8'hAA;
    for (int i = 0; i < 64; i++) a_mem[i] = 24'hFFFE00;
    for (int i = 0; i < 4; i++)  b_mem[i] = 24'hFFFE00;

    // Reset values.
    repeat (3) @(negedge clk);
    check_output("rst_flags", {a_cfg_busy, a_done, a_fail, a_start, a_wr_rd}, 0);
    check_output("rst_addr", {a_fail_index, a_tbl_addr}, 0);
    check_output("rst_dev_addr", a_dev, 32'h78);
    rst_n = 1'b1;

    // Test 1: two writes then END, all ACKed.
    a_mem[0] = {16'h3008, 8'h82};
    a_mem[1] = {16'h3103, 8'h03};
    a_mem[2] = 24'hFFFE00;
    base = a_n;
    apply_stimulus(1'b0);
    check_output("t1_busy_after_start", a_cfg_busy, 1);
    wait_end(1'b0, "t1");
    check_output("t1_pulses", a_n - base, 2);
    check_output("t1_entry0", {a_log_rd[base], a_log_reg[base], a_log_dat[base]}, {1'b0, 16'h3008, 8'h82});
    check_output("t1_entry1", {a_log_rd[base+1], a_log_reg[base+1], a_log_dat[base+1]}, {1'b0, 16'h3103, 8'h03});
    check_output("t1_done_fail_busy", {a_done, a_fail, a_cfg_busy}, 3'b100);
    check_output("t1_tbl_addr", a_tbl_addr, 2);

    // Test 2: entry 1 NACKed twice then ACKed; a stray cfg_start mid-run is ignored.
    a_nack_reg = 16'h3103; a_nack_lim = a_hits + 2;
    base = a_n;
    apply_stimulus(1'b0);
    n = 0;
    while (a_n - base < 1 && n < 200) begin @(negedge clk); n++; end
    apply_stimulus(1'b0);
    wait_end(1'b0, "t2");
    check_output("t2_pulses", a_n - base, 4);
    check_output("t2_retry_reg", a_log_reg[base+3], 32'h3103);
    check_output("t2_done_fail", {a_done, a_fail}, 2'b10);

    // Test 3: entry 0 always NACKed.
    a_nack_reg = 16'h3008; a_nack_lim = a_hits + 1000;
    base = a_n;
    apply_stimulus(1'b0);
    wait_end(1'b0, "t3");
    check_output("t3_pulses", a_n - base, 4);
    check_output("t3_done_fail", {a_done, a_fail}, 2'b01);
    check_output("t3_fail_index", a_fail_index, 0);
    repeat (40) @(negedge clk);
    check_output("t3_no_more_pulses", a_n - base, 4);
    a_nack_lim = 0;

    // Test 4: zero-length delay vs a 2-tick delay between two writes.
    a_mem[1] = 24'hFFFF00;
    a_mem[2] = {16'h3103, 8'h03};
    a_mem[3] = 24'hFFFE00;
    base = a_n;
    apply_stimulus(1'b0);
    wait_end(1'b0, "t4a");
    check_output("t4a_pulses", a_n - base, 2);
    ga = a_log_cyc[base+1] - a_log_cyc[base];
    a_mem[1] = 24'hFFFF02;
    base = a_n;
    apply_stimulus(1'b0);
    wait_end(1'b0, "t4b");
    check_output("t4b_pulses", a_n - base, 2);
    gb = a_log_cyc[base+1] - a_log_cyc[base];
    $display("[TB] t4 delay gap delta = %0d cycles", gb - ga);
    check_output("t4_gap_delta_18_to_22", 32'((gb - ga >= 18) && (gb - ga <= 22)), 1);
    check_output("t4_done", a_done, 1);

    // Verify mode with a full 4-entry table and no END: index wraps to DONE.
    for (int i = 0; i < 4; i++) b_mem[i] = {16'(16'h3000 + i), 8'hAA};
    b_rd_val = 8'hAA;
    base = b_n;
    apply_stimulus(1'b1);
    wait_end(1'b1, "wrap");
    check_output("wrap_pulses", b_n - base, 8);
    check_output("wrap_phase_flags", {b_log_rd[base], b_log_rd[base+1], b_log_rd[base+6], b_log_rd[base+7]}, 4'b0101);
    check_output("wrap_last_reg", b_log_reg[base+7], 32'h3003);
    check_output("wrap_done_fail", {b_done, b_fail}, 2'b10);

    // Test 5: read-back mismatch exhausts the retries on the verify phase.
    b_mem[0] = {16'h3008, 8'hAA};
    b_mem[1] = 24'hFFFE00;
    b_rd_val = 8'h55;
    base = b_n;
    apply_stimulus(1'b1);
    wait_end(1'b1, "t5");
    check_output("t5_pulses", b_n - base, 5);
    check_output("t5_last_is_read", {b_log_rd[base], b_log_rd[base+4], b_log_reg[base+4]}, {2'b01, 16'h3008});
    check_output("t5_done_fail", {b_done, b_fail}, 2'b01);
    check_output("t5_fail_index", b_fail_index, 0);

    // Test 6a: driver never raises busy, so every attempt times out.
    a_mem[0] = {16'h3008, 8'h82};
    a_mem[1] = 24'hFFFE00;
    a_dead = 1'b1;
    base = a_n;
    apply_stimulus(1'b0);
    wait_end(1'b0, "t6a");
    check_output("t6a_pulses", a_n - base, 4);
    check_output("t6a_done_fail", {a_done, a_fail}, 2'b01);

    // Test 6b: driver stays busy forever, then reset lands mid-transfer.
    a_dead = 1'b0; a_stuck = 1'b1;
    base = a_n;
    apply_stimulus(1'b0);
    n = 0;
    while (a_n - base < 1 && n < 200) begin @(negedge clk); n++; end
    repeat (5) @(negedge clk);
    check_output("t6b_busy_before_reset", {a_cfg_busy, a_reg}, {1'b1, 16'h3008});
    rst_n = 1'b0;
    #1;
    check_output("t6b_rst_flags", {a_cfg_busy, a_done, a_fail, a_start, a_wr_rd}, 0);
    check_output("t6b_rst_addr", {a_fail_index, a_tbl_addr}, 0);
    check_output("t6b_rst_regdata", {a_reg, a_data}, 0);
    check_output("t6b_rst_dev_addr", a_dev, 32'h78);
    a_stuck = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    check_output("invariants", viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
